// File: rtl/pick_entry_buffer.sv
// Player-pick store for the roulette game: collects distinct wheel positions
// from the keypad, locks them, then counts hits against the result one slot per cycle.
module pick_entry_buffer #(
  parameter int NUM_POS   = 8,
  parameter int MAX_PICKS = 4,
  parameter int POS_W     = 3,
  parameter int CNT_W     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       enable,
  input  logic [CNT_W-1:0]           pick_limit,
  input  logic                       key_valid,
  input  logic [3:0]                 key_value,
  input  logic                       check_req,
  input  logic [POS_W-1:0]           result_pos,
  output logic [MAX_PICKS*POS_W-1:0] picks_flat,
  output logic [CNT_W-1:0]           pick_count,
  output logic                       entry_full,
  output logic                       locked,
  output logic                       reject_pulse,
  output logic                       check_done,
  output logic [CNT_W-1:0]           hit_count,
  output logic                       win_flag
);

  typedef enum logic [1:0] {ENTRY, LOCKED, CHECK, DONE} state_t;

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_PICKS);
  localparam logic [3:0]       KEY_BS = 4'd10;
  localparam logic [3:0]       KEY_CA = 4'd11;
  localparam logic [3:0]       KEY_OK = 4'd12;

  state_t           state;
  logic [POS_W-1:0] slots [MAX_PICKS];
  logic [CNT_W-1:0] idx;
  logic [CNT_W-1:0] lim;
  logic [POS_W-1:0] key_pos;
  logic             is_digit;
  logic             is_dup;
  logic             match;
  logic             key_act;
  logic             wipe;

  always_comb begin
    if (pick_limit == '0)
      lim = CNT_W'(1);
    else if (pick_limit > MAX_C)
      lim = MAX_C;
    else
      lim = pick_limit;
  end

  always_comb begin
    key_pos  = POS_W'(key_value - 4'd1);
    is_digit = (key_value >= 4'd1) && (key_value <= 4'(NUM_POS));
    is_dup   = 1'b0;
    match    = 1'b0;
    for (int i = 0; i < MAX_PICKS; i++) begin
      if ((CNT_W'(i) < pick_count) && (slots[i] == key_pos))
        is_dup = 1'b1;
      if ((CNT_W'(i) == idx) && (slots[i] == result_pos))
        match = 1'b1;
    end
  end

  // Key 11 wipes from ENTRY (when enabled) and from DONE (always).
  assign key_act = key_valid && enable && (state == ENTRY);
  assign wipe    = clear
                 || (key_act && key_value == KEY_CA)
                 || (key_valid && state == DONE && key_value == KEY_CA);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ENTRY;
      pick_count   <= '0;
      idx          <= '0;
      hit_count    <= '0;
      win_flag     <= 1'b0;
      reject_pulse <= 1'b0;
      check_done   <= 1'b0;
      for (int i = 0; i < MAX_PICKS; i++) slots[i] <= '0;
    end else begin
      reject_pulse <= 1'b0;
      check_done   <= 1'b0;
      if (wipe) begin
        state      <= ENTRY;
        pick_count <= '0;
        idx        <= '0;
        hit_count  <= '0;
        win_flag   <= 1'b0;
        for (int i = 0; i < MAX_PICKS; i++) slots[i] <= '0;
      end else begin
        unique case (state)
          ENTRY: begin
            if (key_act) begin
              if (is_digit) begin
                if (pick_count < lim && !is_dup) begin
                  for (int i = 0; i < MAX_PICKS; i++)
                    if (CNT_W'(i) == pick_count) slots[i] <= key_pos;
                  pick_count <= pick_count + 1'b1;
                end else begin
                  reject_pulse <= 1'b1;
                end
              end else if (key_value == KEY_BS) begin
                if (pick_count != '0) begin
                  for (int i = 0; i < MAX_PICKS; i++)
                    if (CNT_W'(i) == pick_count - 1'b1) slots[i] <= '0;
                  pick_count <= pick_count - 1'b1;
                end else begin
                  reject_pulse <= 1'b1;
                end
              end else if (key_value == KEY_OK) begin
                if (pick_count >= lim) state <= LOCKED;
                else reject_pulse <= 1'b1;
              end else begin
                reject_pulse <= 1'b1;
              end
            end
          end
          LOCKED, DONE: begin
            if (check_req) begin
              state     <= CHECK;
              idx       <= '0;
              hit_count <= '0;
            end
          end
          CHECK: begin
            hit_count <= hit_count + CNT_W'(match);
            idx       <= idx + 1'b1;
            if (idx + 1'b1 >= pick_count) begin
              state      <= DONE;
              check_done <= 1'b1;
              win_flag   <= (hit_count != '0) || match;
            end
          end
          default: state <= ENTRY;
        endcase
      end
    end
  end

  for (genvar g = 0; g < MAX_PICKS; g++) begin : g_flat
    assign picks_flat[g*POS_W +: POS_W] = slots[g];
  end

  assign entry_full = (pick_count >= lim);
  assign locked     = (state != ENTRY);

endmodule

// File: tb/tb_pick_entry_buffer.sv
// Bench for pick_entry_buffer: two instances (8 pos/4 picks and 6 pos/8 picks)
// share one stimulus stream and are compared every cycle against a pick-list model.
module tb_pick_entry_buffer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clear, enable, key_valid, check_req;
  logic [3:0] pick_limit, key_value;
  logic [2:0] result_pos;

  logic [11:0] pf0;
  logic [23:0] pf1;
  logic [3:0]  pc [2];
  logic [3:0]  hc [2];
  logic        ef [2], lk [2], rp [2], cd [2], wf [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pick_entry_buffer #(.NUM_POS(8), .MAX_PICKS(4), .POS_W(3), .CNT_W(4)) u_dut0 (
    .clk(clk), .rst(rst), .clear(clear), .enable(enable), .pick_limit(pick_limit),
    .key_valid(key_valid), .key_value(key_value), .check_req(check_req),
    .result_pos(result_pos), .picks_flat(pf0), .pick_count(pc[0]),
    .entry_full(ef[0]), .locked(lk[0]), .reject_pulse(rp[0]),
    .check_done(cd[0]), .hit_count(hc[0]), .win_flag(wf[0]));

  pick_entry_buffer #(.NUM_POS(6), .MAX_PICKS(8), .POS_W(3), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst(rst), .clear(clear), .enable(enable), .pick_limit(pick_limit),
    .key_valid(key_valid), .key_value(key_value), .check_req(check_req),
    .result_pos(result_pos), .picks_flat(pf1), .pick_count(pc[1]),
    .entry_full(ef[1]), .locked(lk[1]), .reject_pulse(rp[1]),
    .check_done(cd[1]), .hit_count(hc[1]), .win_flag(wf[1]));

  // Model: ordered pick list plus a phase (0 entry, 1 locked, 2 checking, 3 done).
  int np [2] = '{8, 6};
  int mp [2] = '{4, 8};
  int m_pick [2][8];
  int m_cnt [2], m_ph [2], m_steps [2], m_hits [2];
  int m_rej [2], m_done [2], m_win [2];

  function automatic int lim_of(int j);
    int l;
    l = int'(pick_limit);
    if (l < 1) l = 1;
    if (l > mp[j]) l = mp[j];
    return l;
  endfunction

  task automatic model_wipe(int j);
    for (int i = 0; i < 8; i++) m_pick[j][i] = 0;
    m_cnt[j] = 0; m_ph[j] = 0; m_steps[j] = 0; m_hits[j] = 0; m_win[j] = 0;
  endtask

  task automatic model_step(int j);
    int k, dup;
    k = int'(key_value);
    m_rej[j]  = 0;
    m_done[j] = 0;
    if (clear || (key_valid && k == 11 && ((m_ph[j] == 0 && enable) || m_ph[j] == 3))) begin
      model_wipe(j);
    end else if (m_ph[j] == 0) begin
      if (key_valid && enable) begin
        if (k >= 1 && k <= np[j]) begin
          dup = 0;
          for (int i = 0; i < m_cnt[j]; i++) if (m_pick[j][i] == k - 1) dup = 1;
          if (m_cnt[j] < lim_of(j) && dup == 0) begin
            m_pick[j][m_cnt[j]] = k - 1;
            m_cnt[j]++;
          end else m_rej[j] = 1;
        end else if (k == 10) begin
          if (m_cnt[j] > 0) begin
            m_cnt[j]--;
            m_pick[j][m_cnt[j]] = 0;
          end else m_rej[j] = 1;
        end else if (k == 12) begin
          if (m_cnt[j] >= lim_of(j)) m_ph[j] = 1;
          else m_rej[j] = 1;
        end else m_rej[j] = 1;
      end
    end else if (m_ph[j] == 2) begin
      m_steps[j]++;
      m_hits[j] = 0;
      for (int i = 0; i < m_steps[j]; i++)
        if (m_pick[j][i] == int'(result_pos)) m_hits[j]++;
      if (m_steps[j] == m_cnt[j]) begin
        m_done[j] = 1;
        m_win[j]  = (m_hits[j] != 0) ? 1 : 0;
        m_ph[j]   = 3;
      end
    end else if (check_req) begin
      m_ph[j] = 2; m_steps[j] = 0; m_hits[j] = 0;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    for (int j = 0; j < 2; j++) begin
      if (rst) begin
        model_wipe(j);
        m_rej[j] = 0; m_done[j] = 0;
      end else model_step(j);
    end
  end

  task automatic chk(string name, int j, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s inst%0d at %0t: got=%0d want=%0d", name, j, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    int pf_exp, pf_act;
    for (int j = 0; j < 2; j++) begin
      pf_exp = 0;
      for (int i = 0; i < mp[j]; i++) pf_exp |= m_pick[j][i] << (3 * i);
      pf_act = (j == 0) ? int'(pf0) : int'(pf1);
      chk("picks_flat", j, pf_act, pf_exp);
      chk("pick_count", j, int'(pc[j]), m_cnt[j]);
      chk("entry_full", j, int'(ef[j]), (m_cnt[j] >= lim_of(j)) ? 1 : 0);
      chk("locked", j, int'(lk[j]), (m_ph[j] != 0) ? 1 : 0);
      chk("reject_pulse", j, int'(rp[j]), m_rej[j]);
      chk("check_done", j, int'(cd[j]), m_done[j]);
      chk("hit_count", j, int'(hc[j]), m_hits[j]);
      chk("win_flag", j, int'(wf[j]), m_win[j]);
    end
  end

  // Inputs change 2 time units after the falling edge, after the compare has sampled.
  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic key(int k);
    key_valid = 1'b1;
    key_value = 4'(k);
    tick();
    key_valid = 1'b0;
    key_value = 4'd0;
  endtask

  task automatic pulse_check();
    check_req = 1'b1;
    tick();
    check_req = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    clear = 0; enable = 1; key_valid = 0; key_value = 0;
    check_req = 0; result_pos = 0; pick_limit = 4'd3;
    #1 rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("lit_reset_count", 0, int'(pc[0]), 0);
    chk("lit_reset_locked", 0, int'(lk[0]), 0);

    // Three picks, confirm, one hit on position 4
    key(2); key(5); key(8);
    chk("lit_t1_picks", 0, int'(pf0[8:0]), 9'h1E1);
    key(12);
    chk("lit_t1_locked", 0, int'(lk[0]), 1);
    chk("lit_t1_small_unlocked", 1, int'(lk[1]), 0);
    result_pos = 3'd4;
    pulse_check();
    tick(); tick();
    chk("lit_t1_done_early", 0, int'(cd[0]), 0);
    tick();
    chk("lit_t1_done", 0, int'(cd[0]), 1);
    chk("lit_t1_hits", 0, int'(hc[0]), 1);
    chk("lit_t1_win", 0, int'(wf[0]), 1);
    tick();
    pulse_clear();

    // Duplicate and overflow
    pick_limit = 4'd2;
    key(3); key(3);
    chk("lit_t2_dup", 0, int'(rp[0]), 1);
    key(6); key(7);
    chk("lit_t2_full", 0, int'(rp[0]), 1);
    chk("lit_t2_count", 0, int'(pc[0]), 2);
    pulse_clear();

    // Backspace and early confirm
    key(1);
    chk("lit_t3_one", 0, int'(pc[0]), 1);
    key(10);
    chk("lit_t3_zero", 0, int'(pc[0]), 0);
    key(10);
    chk("lit_t3_bs_rej", 0, int'(rp[0]), 1);
    key(12);
    chk("lit_t3_ok_rej", 0, int'(rp[0]), 1);
    chk("lit_t3_entry", 0, int'(lk[0]), 0);

    // Clear aborts a running check
    pick_limit = 4'd4;
    key(1); key(2); key(3); key(4); key(12);
    result_pos = 3'd2;
    pulse_check();
    pulse_clear();
    repeat (5) tick();
    chk("lit_t4_count", 0, int'(pc[0]), 0);
    chk("lit_t4_locked", 0, int'(lk[0]), 0);

    // Limit 0 acts as 1; digit 7 illegal on a 6-position wheel
    pick_limit = 4'd0;
    key(7);
    chk("lit_t5_bad_digit", 1, int'(rp[1]), 1);
    key(3);
    chk("lit_t5_single", 1, int'(pc[1]), 1);
    key(12);
    result_pos = 3'd5;
    pulse_check();
    tick();
    chk("lit_t5_done", 1, int'(cd[1]), 1);
    chk("lit_t5_miss", 1, int'(hc[1]), 0);
    chk("lit_t5_nowin", 1, int'(wf[1]), 0);
    result_pos = 3'd2;
    pulse_check();
    tick();
    chk("lit_t5_rerun_hit", 1, int'(hc[1]), 1);
    enable = 1'b0;
    key(11);
    chk("lit_t5_exit_done", 1, int'(lk[1]), 0);

    // Gating
    pick_limit = 4'd3;
    key(4);
    chk("lit_t6_gated_rej", 0, int'(rp[0]), 0);
    key(12);
    chk("lit_t6_gated_cnt", 0, int'(pc[0]), 0);
    enable = 1'b1;
    pick_limit = 4'd1;
    key(4); key(12); key(5);
    chk("lit_t6_locked_key", 0, int'(rp[0]), 0);
    key(11);
    chk("lit_t6_locked_hold", 0, int'(lk[0]), 1);
    pulse_clear();

    // Limit lowered below the count: confirm accepted, all picks checked
    pick_limit = 4'd3;
    key(1); key(2); key(3);
    pick_limit = 4'd1;
    tick();
    chk("lit_t7_full", 0, int'(ef[0]), 1);
    key(5);
    chk("lit_t7_rej", 0, int'(rp[0]), 1);
    key(12);
    result_pos = 3'd2;
    pulse_check();
    tick(); tick(); tick();
    chk("lit_t7_done", 0, int'(cd[0]), 1);
    chk("lit_t7_hits", 0, int'(hc[0]), 1);
    pulse_clear();

    // Asynchronous reset mid-entry
    pick_limit = 4'd3;
    key(1); key(2);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("lit_rst_count", 0, int'(pc[0]), 0);
    chk("lit_rst_picks", 0, int'(pf0), 0);
    tick();
    rst = 1'b0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pick_entry_buffer.md
Name: pick_entry_buffer

Overview:
Parametrised player-pick store and hit evaluator for the roulette game. It replaces the fixed 4-slot, 3-bit user-number registers.
- Collects up to MAX_PICKS distinct wheel positions from the keypad stream.
- Supports backspace, clear and confirm/lock.
- After a spin, counts hits against the wheel result serially.
- Sits between Button_Keypad and Money_Manager; the game FSM drives enable, pick_limit, clear and check_req.

Parameters:
NUM_POS, 8, wheel positions; legal 2..9 (digit keys 1..NUM_POS map to positions 0..NUM_POS-1)
MAX_PICKS, 4, storage slots; legal 1..8
POS_W, 3, position index width; must equal ceil(log2(NUM_POS)), minimum 1
CNT_W, 4, count width; must hold 0..MAX_PICKS

Ports:
clk  in  1  system clock
rst  in  1  reset
clear  in  1  synchronous clear of picks and results; highest priority
enable  in  1  entry window open (FSM in number-input state)
pick_limit  in  CNT_W  picks required for this bet
key_valid  in  1  one-cycle key strobe
key_value  in  4  1..9 digit, 10 backspace, 11 clear-all, 12 confirm
check_req  in  1  pulse: evaluate picks against result_pos
result_pos  in  POS_W  wheel stop position, stable while checking
picks_flat  out  MAX_PICKS*POS_W  slot i at bits [i*POS_W +: POS_W]
pick_count  out  CNT_W  number of stored picks
entry_full  out  1  pick_count >= lim
locked  out  1  state is LOCKED, CHECK or DONE
reject_pulse  out  1  one-cycle pulse on an illegal key
check_done  out  1  one-cycle pulse when results are valid
hit_count  out  CNT_W  matches found
win_flag  out  1  hit_count != 0, registered with check_done

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. All outputs and slots are 0; state is ENTRY.
- lim = min(max(pick_limit, 1), MAX_PICKS), evaluated combinationally every cycle.
- States: ENTRY, LOCKED, CHECK, DONE.
- clear (any state): next edge zeroes slots, pick_count, hit_count and win_flag, and goes to ENTRY. An in-progress check is aborted with no check_done.
- ENTRY, key_valid && enable:
  - Digit d in 1..NUM_POS: accepted if pick_count < lim and d-1 is not already stored. Slot[pick_count] <= d-1; pick_count increments.
  - Any other digit, a duplicate, or a digit when full: reject_pulse, no change.
  - 10 (backspace): if pick_count > 0, top slot <= 0 and pick_count decrements; otherwise reject.
  - 11 (clear-all): same effect as clear, no reject.
  - 12 (confirm): if pick_count >= lim, go to LOCKED; otherwise reject.
  - Codes 0, 13-15: reject.
- With enable=0, or in any state other than ENTRY: keys are ignored, with no reject and no state change.
- Duplicate detection compares against the valid slots only (index < pick_count); unused slots always read 0.
- LOCKED: check_req at edge E0 goes to CHECK with idx=0 and hit_count=0. check_req in other states is ignored. Simultaneous key and check_req in ENTRY: the key is processed and check_req is dropped.
- CHECK: at edges E1..Ek (k = pick_count), hit_count += (slot[idx] == result_pos) and idx increments.
- At Ek: check_done <= 1 for one cycle, win_flag <= final hit_count != 0, state goes to DONE. Latency from check_req is k edges.
- DONE: results and picks hold. check_req re-runs the check. Only clear or key 11 returns to ENTRY; key 11 is accepted regardless of enable in DONE.
- pick_limit lowered below pick_count during ENTRY: entry_full=1, digits are rejected, confirm is accepted, and all pick_count picks are checked.
- No arithmetic wrap: pick_count never exceeds MAX_PICKS, and hit_count never exceeds pick_count.

Test Plan:
1. Defaults, pick_limit=3: keys 2,5,8, then 12 -> picks_flat[8:0]=3'd7,3'd4,3'd1 (slot2..slot0), pick_count=3, locked=1. result_pos=4, check_req -> check_done 3 edges later, hit_count=1, win_flag=1.
2. Duplicate and overflow, pick_limit=2: keys 3,3 -> reject on the second 3. Keys 6,7 -> 6 accepted, 7 rejected (full), pick_count=2.
3. Backspace and confirm, pick_limit=2: keys 1,10,10 -> count 1, then 0, then reject. Key 12 at count 0 -> reject, stays in ENTRY.
4. Clear mid-check, MAX_PICKS=4, 4 picks locked: assert clear one edge after check_req -> no check_done, all outputs 0, ENTRY.
5. NUM_POS=6, MAX_PICKS=8: key 7 -> reject. pick_limit=0 -> lim=1, single pick, confirm accepted. Miss result -> hit_count=0, win_flag=0.
6. Gating: enable=0 with keys 4,12 -> no change, no reject. Key press while LOCKED -> ignored. rst asserted mid-entry -> immediate zeroed outputs.
